pipe_stage_latch: RTL and testbench
===================================

# pipe_stage_latch

Parametrised pipeline stage register that carries any packed stage struct (fetch, decode, execute, memory, write-back) between two pipeline stages with a valid/ready handshake. It replaces hand-written per-stage enable/flush latches with one block that supports back-pressure, flush, an optional two-entry skid buffer that registers `in_ready`, and saturating stall and bubble counters for performance analysis. One instance sits between each pair of adjacent stages of the CPU pipeline.

## Interface
Parameters:
- `DATA_W`, 32: width of the carried payload; instantiated as `$bits(<stage struct>)`.
- `SKID`, 1: 1 selects the two-entry skid buffer with registered `in_ready`; 0 selects a single register with combinational `in_ready`.
- `CNT_W`, 16: width of each performance counter.

Ports:
- `CLK` in 1: clock; all state updates on the rising edge.
- `RST` in 1: reset; synchronous, active-high.
- `in_valid` in 1: upstream stage presents a payload.
- `in_ready` out 1: latch accepts a payload this cycle.
- `in_data` in `DATA_W`: upstream payload.
- `out_valid` out 1: latch holds a payload for the downstream stage.
- `out_ready` in 1: downstream stage consumes the payload this cycle.
- `out_data` out `DATA_W`: held payload.
- `flush` in 1: discard all held payloads; used on branch or jump redirect.
- `stall_cnt` out `CNT_W`: number of cycles with `out_valid && !out_ready`.
- `bubble_cnt` out `CNT_W`: number of cycles with `!out_valid && out_ready`.

## Operation
- Transfer in: `in_valid && in_ready`. Transfer out: `out_valid && out_ready`.
- States: EMPTY, ONE, TWO. TWO exists only when `SKID=1`.
- The main register drives `out_data`. The skid register is used only in TWO.
- Transitions for `SKID=1`, with `in_ready = (state != TWO)`, taken from the state register only:
  - EMPTY: on in-transfer, main <= `in_data`, go to ONE.
  - ONE, out-transfer and in-transfer: main <= `in_data`, stay in ONE.
  - ONE, out-transfer only: go to EMPTY.
  - ONE, in-transfer only: skid <= `in_data`, go to TWO.
  - ONE, neither transfer: hold.
  - TWO, out-transfer: main <= skid, go to ONE. Otherwise hold.
- Transitions for `SKID=0`, with `in_ready = !out_valid || out_ready` (combinational):
  - In-transfer: main <= `in_data`, go to ONE.
  - Out-transfer without in-transfer: go to EMPTY.
- `out_valid = (state != EMPTY)`.
- Flush has priority over every transition except `RST`. On flush the state goes to EMPTY, and a payload arriving in the same cycle is dropped even though `in_ready` is high. Register contents are left unchanged; only validity clears.
- Counters saturate at all-ones and never wrap. They are cleared only by `RST`, not by `flush`. They sample the handshake signals in every cycle, including a flush cycle.
- Payload bits are opaque; no field is interpreted. Held data never changes without a transfer.

## Timing
- Reset values: state EMPTY, `out_valid` 0, `out_data` 0, skid register 0, `in_ready` 1, both counters 0.
- Latency is 1 cycle from in-transfer into EMPTY to `out_valid` high.
- Throughput is 1 payload per cycle while `out_ready` stays high in both modes.
- `SKID=1`: `in_ready` falls in the cycle after the first stalled accept, so upstream may issue exactly one extra payload after back-pressure begins. No combinational path exists from `out_ready` to `in_ready`.
- `SKID=0`: a combinational path from `out_ready` to `in_ready` is permitted.
- A flush in cycle N gives `out_valid` 0 in cycle N+1. A new payload may be accepted in cycle N+1.
- `RST` asserted mid-stall discards both entries. `out_valid` is 0 in the next cycle.
- Counter update is visible the cycle after the counted condition.

## Structure
- `pipe_latch_pkg` holds the state enum `latch_state_t` {EMPTY, ONE, TWO}.
- Stage structs remain in the existing pipeline package. The latch is type-agnostic and is wrapped by casting the struct to and from `logic [DATA_W-1:0]`.
- Sub-module `sat_counter` (parameter `W`; ports `CLK`, `RST`, `inc`, `count`) is instantiated twice.
- The `SKID` mode is chosen with a generate branch. No skid register exists when `SKID=0`.

## Test plan
- Stream: with `SKID=1`, drive 8 payloads 0x1..0x8 back-to-back with `out_ready`=1 → outputs appear in order, one per cycle, first one cycle after input; `stall_cnt`=0.
- Skid: with ONE holding 0xA, drop `out_ready` while sending 0xB → state TWO, `in_ready`=0 next cycle. Raise `out_ready` → 0xA then 0xB, no loss or duplication; `stall_cnt` equals the stalled cycles.
- Flush: in TWO, assert `flush` with `in_valid`=1, `in_data`=0xC → `out_valid`=0 next cycle, 0xC never emitted, counters unchanged by flush.
- Saturation: with `CNT_W`=4, hold `out_valid`=1 and `out_ready`=0 for 20 cycles → `stall_cnt`=15 and stays there.
- `SKID=0`: with `out_ready` toggling 1,0,1 → `in_ready` tracks `out_ready` combinationally while full; payload order is preserved.
- Reset: assert `RST` in TWO → next cycle `out_valid`=0, `in_ready`=1, `out_data`=0, counters 0.

Source files
------------

// File: rtl/pipe_latch_pkg.sv
// Shared types for the pipeline stage latch.
package pipe_latch_pkg;

  // Occupancy of the latch. TWO is reachable only in skid-buffer mode.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } latch_state_t;

  // True when the latch presents a payload downstream.
  function automatic logic holds_payload(input latch_state_t st);
    return st != EMPTY;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc high, sticks at all-ones,
// cleared only by RST.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: increment unless already saturated.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_latch.sv
// Pipeline stage register with valid/ready handshake, flush, optional
// two-entry skid buffer and saturating stall/bubble counters. The payload is
// opaque: callers cast their stage struct to and from logic [DATA_W-1:0].
module pipe_stage_latch
  import pipe_latch_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter bit SKID   = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  if (SKID) begin : g_skid
    latch_state_t      state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;

    // Next state and payload moves; flush only clears validity.
    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
        state_d = EMPTY;
      end else begin
        case (state_q)
          EMPTY: begin
            if (in_xfer) begin
              main_d  = in_data;
              state_d = ONE;
            end
          end
          ONE: begin
            if (out_xfer && in_xfer) begin
              main_d = in_data;
            end else if (out_xfer) begin
              state_d = EMPTY;
            end else if (in_xfer) begin
              skid_d  = in_data;
              state_d = TWO;
            end
          end
          TWO: begin
            if (out_xfer) begin
              main_d  = skid_q;
              state_d = ONE;
            end
          end
          default: state_d = EMPTY;
        endcase
      end
    end

    // State and payload registers.
    always_ff @(posedge CLK) begin
      // NOTE: payload registers are reset too, since out_data must read 0 after reset.
      if (RST) begin
        state_q <= EMPTY;
        main_q  <= '0;
        skid_q  <= '0;
      end else begin
        state_q <= state_d;
        main_q  <= main_d;
        skid_q  <= skid_d;
      end
    end

    // in_ready comes from the state register only, never from out_ready.
    assign in_ready  = (state_q != TWO);
    assign out_valid = holds_payload(state_q);
    assign out_data  = main_q;

  end else begin : g_single
    latch_state_t      state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;

    // Next state for the single-register latch.
    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      if (flush) begin
        state_d = EMPTY;
      end else if (in_xfer) begin
        main_d  = in_data;
        state_d = ONE;
      end else if (out_xfer) begin
        state_d = EMPTY;
      end
    end

    // State and payload registers.
    always_ff @(posedge CLK) begin
      if (RST) begin
        state_q <= EMPTY;
        main_q  <= '0;
      end else begin
        state_q <= state_d;
        main_q  <= main_d;
      end
    end

    // Accept when empty or when the held payload leaves this cycle.
    assign in_ready  = !out_valid || out_ready;
    assign out_valid = holds_payload(state_q);
    assign out_data  = main_q;
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (out_valid && !out_ready),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (!out_valid && out_ready),
    .count (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_latch.sv
// Self-checking bench: a skid-mode latch with 4-bit counters (a_*) and a
// single-register latch with 16-bit counters (b_*) run side by side. A queue
// scoreboard per instance predicts out_valid, in_ready, out_data and counters.
module tb_pipe_stage_latch;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_iv, a_ir, a_ov, a_ordy, a_fl;
  logic [31:0] a_d, a_od;
  logic [3:0]  a_sc, a_bc;
  logic        b_iv, b_ir, b_ov, b_ordy, b_fl;
  logic [31:0] b_d, b_od;
  logic [15:0] b_sc, b_bc;

  pipe_stage_latch #(.DATA_W(32), .SKID(1'b1), .CNT_W(4)) dut_a (
    .CLK(clk), .RST(rst), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_d),
    .out_valid(a_ov), .out_ready(a_ordy), .out_data(a_od), .flush(a_fl),
    .stall_cnt(a_sc), .bubble_cnt(a_bc)
  );

  pipe_stage_latch #(.DATA_W(32), .SKID(1'b0), .CNT_W(16)) dut_b (
    .CLK(clk), .RST(rst), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_d),
    .out_valid(b_ov), .out_ready(b_ordy), .out_data(b_od), .flush(b_fl),
    .stall_cnt(b_sc), .bubble_cnt(b_bc)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int unsigned st_m[2];
  int unsigned bb_m[2];

  typedef struct {
    bit          sel;   // 1: skid instance, 0: single-register instance
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        fl;
    logic        exp_ov;
    logic        exp_ir;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Compare one instance against its model, then advance the model.
  task automatic eval(input bit sel);
    logic        iv, ir, ov, ordy, fl;
    logic [31:0] d, od, sc, bc, front;
    int          sz;
    int unsigned sat;
    string       p;
    if (sel) begin
      iv = a_iv; ir = a_ir; ov = a_ov; ordy = a_ordy; fl = a_fl; d = a_d; od = a_od;
      sc = 32'(a_sc); bc = 32'(a_bc); sz = qa.size(); front = (sz > 0) ? qa[0] : 32'h0;
      sat = 15; p = "skid";
    end else begin
      iv = b_iv; ir = b_ir; ov = b_ov; ordy = b_ordy; fl = b_fl; d = b_d; od = b_od;
      sc = 32'(b_sc); bc = 32'(b_bc); sz = qb.size(); front = (sz > 0) ? qb[0] : 32'h0;
      sat = 65535; p = "single";
    end
    check({p, "_out_valid"}, 32'(ov), 32'(sz != 0));
    check({p, "_in_ready"}, 32'(ir), sel ? 32'(sz < 2) : 32'((sz == 0) || ordy));
    if (sz != 0) check({p, "_out_data"}, od, front);
    check({p, "_stall_cnt"}, sc, st_m[sel]);
    check({p, "_bubble_cnt"}, bc, bb_m[sel]);
    if (rst) begin
      if (sel) qa.delete(); else qb.delete();
      st_m[sel] = 0;
      bb_m[sel] = 0;
    end else begin
      if (ov && !ordy && st_m[sel] < sat) st_m[sel]++;
      if (!ov && ordy && bb_m[sel] < sat) bb_m[sel]++;
      if (ov && ordy && sz > 0) begin
        if (sel) void'(qa.pop_front()); else void'(qb.pop_front());
      end
      if (fl) begin
        if (sel) qa.delete(); else qb.delete();
      end else if (iv && ir) begin
        if (sel) qa.push_back(d); else qb.push_back(d);
      end
    end
  endtask

  // One clock cycle: inputs were driven after the previous falling edge.
  task automatic step();
    #1;
    eval(1'b1);
    eval(1'b0);
    @(negedge clk);
  endtask

  task automatic idle();
    a_iv = 0; a_d = '0; a_ordy = 0; a_fl = 0;
    b_iv = 0; b_d = '0; b_ordy = 0; b_fl = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("rst_a_out_valid", 32'(a_ov), 32'h0);
    check("rst_a_in_ready", 32'(a_ir), 32'h1);
    check("rst_a_out_data", a_od, 32'h0);
    check("rst_a_stall", 32'(a_sc), 32'h0);
    check("rst_a_bubble", 32'(a_bc), 32'h0);
    check("rst_b_out_valid", 32'(b_ov), 32'h0);
    check("rst_b_in_ready", 32'(b_ir), 32'h1);
    check("rst_b_stall", 32'(b_sc), 32'h0);
  endtask

  initial begin
    vec_t tbl[$];
    // Skid instance: stall into TWO, drain, then flush from TWO and from ONE.
    tbl.push_back('{1'b1, 1'b1, 32'hA, 1'b1, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 32'hB, 1'b0, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 32'hD, 1'b0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 32'hE, 1'b0, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 32'hC, 1'b0, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 32'hF, 1'b0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 32'hC, 1'b0, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1});
    // Single-register instance: out_ready toggles 1,0,1 while full, then flush.
    tbl.push_back('{1'b0, 1'b1, 32'h11, 1'b1, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 32'h12, 1'b1, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 32'h13, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 32'h13, 1'b1, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 32'h14, 1'b0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 32'h15, 1'b0, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1});

    st_m[0] = 0; st_m[1] = 0; bb_m[0] = 0; bb_m[1] = 0;
    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("init_a_out_valid", 32'(a_ov), 32'h0);
    check("init_a_in_ready", 32'(a_ir), 32'h1);
    check("init_a_out_data", a_od, 32'h0);
    check("init_b_out_valid", 32'(b_ov), 32'h0);
    @(negedge clk);

    // Back-to-back stream of 8 payloads into the skid instance.
    for (int k = 0; k < 8; k++) begin
      a_iv = 1'b1; a_d = 32'(k + 1); a_ordy = 1'b1;
      step();
    end
    a_iv = 1'b0;
    repeat (2) step();
    check("stream_stall_cnt", 32'(a_sc), 32'h0);
    check("stream_queue_drained", 32'(qa.size()), 32'h0);

    // Table-driven handshake vectors.
    do_reset();
    foreach (tbl[i]) begin
      idle();
      if (tbl[i].sel) begin
        a_iv = tbl[i].iv; a_d = tbl[i].d; a_ordy = tbl[i].ordy; a_fl = tbl[i].fl;
      end else begin
        b_iv = tbl[i].iv; b_d = tbl[i].d; b_ordy = tbl[i].ordy; b_fl = tbl[i].fl;
      end
      #1;
      check($sformatf("vec%0d_out_valid", i),
            tbl[i].sel ? 32'(a_ov) : 32'(b_ov), 32'(tbl[i].exp_ov));
      check($sformatf("vec%0d_in_ready", i),
            tbl[i].sel ? 32'(a_ir) : 32'(b_ir), 32'(tbl[i].exp_ir));
      step();
    end
    idle();
    #1;
    check("tbl_a_stall_total", 32'(a_sc), 32'd6);
    check("tbl_a_bubble_total", 32'(a_bc), 32'd3);
    check("tbl_b_stall_total", 32'(b_sc), 32'd2);
    check("tbl_b_bubble_total", 32'(b_bc), 32'd2);

    // Stall counter saturation on the 4-bit instance.
    do_reset();
    a_iv = 1'b1; a_d = 32'h5A; a_ordy = 1'b0;
    step();
    a_iv = 1'b0;
    repeat (20) step();
    check("sat_stall_cnt", 32'(a_sc), 32'd15);
    step();
    check("sat_stall_hold", 32'(a_sc), 32'd15);

    // Reset while the skid instance holds two entries.
    a_iv = 1'b1; a_d = 32'h77;
    step();
    a_iv = 1'b0;
    #1;
    check("two_in_ready_low", 32'(a_ir), 32'h0);
    check("two_out_data", a_od, 32'h5A);
    step();
    do_reset();

    // Traffic resumes normally after reset.
    a_iv = 1'b1; a_d = 32'h21; a_ordy = 1'b1;
    step();
    a_d = 32'h22;
    step();
    a_iv = 1'b0;
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
